piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 27 ++
 rtl/piso_bit_counter.sv | 48 ++++
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out serializer:
//   state_e      - serializer FSM states (IDLE, SHIFT)
//   PARITY_EXTRA - number of extra serial cycles per word (1 when the
//                  PISO_PARITY_EN macro is defined, 0 otherwise)
//   cnt_width()  - width of a counter able to hold the values 0..width
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef PISO_PARITY_EN
    localparam int PARITY_EXTRA = 1;
`else
    localparam int PARITY_EXTRA = 0;
`endif

    // Bits needed to count from 0 up to and including 'width'.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Bit-position counter for the serializer.
// Ports:
//   CLK     rising-edge clock
//   RESET   asynchronous active-high reset (count -> 0)
//   clr_i   synchronous clear (priority over increment)
//   inc_i   increment by one
//   tc_o    high while the count equals TC_VAL
// -----------------------------------------------------------------------------
module piso_bit_counter #(
    parameter int CNT_W  = 3,
    parameter int TC_VAL = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Accepts a WIDTH-bit word on a valid/ready handshake and transmits it
// LSB-first, one bit per clock, with a serial valid strobe and a last-bit flag.
// Optional build macro: PISO_PARITY_EN appends one even-parity bit per word
// (word then occupies WIDTH+1 serial cycles, O_last on the parity cycle).
// Ports:
//   CLK      rising-edge clock
//   RESET    asynchronous active-high reset
//   I        parallel word to transmit
//   I_valid  producer presents a word on I
//   I_ready  a word is accepted this cycle (IDLE, or final bit of a word)
//   O        serial data bit (registered)
//   O_valid  O carries a payload (or parity) bit
//   O_last   current O bit is the final bit of the word
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic             O,
    output logic             O_valid,
    output logic             O_last
);

    localparam int CNT_W    = cnt_width(WIDTH);
    localparam int SR_W     = WIDTH + PARITY_EXTRA;
    localparam int LAST_CNT = SR_W - 1;

    state_e            state_q;
    logic [SR_W-1:0]   shreg_q;
    logic [SR_W-1:0]   load_d;
    logic              o_valid_q;
    logic              o_last_q;
    logic              accept;
    logic              pre_last;
    logic              cnt_clr;
    logic              cnt_inc;

    // Word image loaded into the shift register; parity (when built in)
    // rides above the MSB so it falls out of bit 0 after the payload.
    always_comb begin
`ifdef PISO_PARITY_EN
        load_d = {^I, I};
`else
        load_d = I;
`endif
    end

    // Ready is forced low during reset so I_valid is ignored there.
    assign I_ready = ~RESET & ((state_q == IDLE) | o_last_q);
    assign accept  = I_valid & I_ready;

    // Counter restarts on every load and on the return to IDLE; it advances
    // on each non-final SHIFT cycle, so it tops out at LAST_CNT.
    assign cnt_clr = accept | o_last_q;
    assign cnt_inc = (state_q == SHIFT) & ~o_last_q;

    // pre_last flags the cycle before the last one, so O_last can be
    // registered and lines up with the final bit.
    piso_bit_counter #(
        .CNT_W  (CNT_W),
        .TC_VAL (LAST_CNT - 1)
    ) u_bit_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (pre_last)
    );

    // Serializer FSM with registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= SHIFT;
                        shreg_q   <= load_d;
                        o_valid_q <= 1'b1;
                        o_last_q  <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        shreg_q   <= '0;
                        o_valid_q <= 1'b0;
                        o_last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (o_last_q && accept) begin
                        // Back-to-back: next word follows with no gap.
                        state_q   <= SHIFT;
                        shreg_q   <= load_d;
                        o_valid_q <= 1'b1;
                        o_last_q  <= 1'b0;
                    end else if (o_last_q) begin
                        state_q   <= IDLE;
                        shreg_q   <= '0;
                        o_valid_q <= 1'b0;
                        o_last_q  <= 1'b0;
                    end else begin
                        state_q   <= SHIFT;
                        shreg_q   <= {1'b0, shreg_q[SR_W-1:1]};
                        o_valid_q <= 1'b1;
                        o_last_q  <= pre_last;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    shreg_q   <= '0;
                    o_valid_q <= 1'b0;
                    o_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign O       = shreg_q[0];
    assign O_valid = o_valid_q;
    assign O_last  = o_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a WIDTH=4 instance and a WIDTH=2
// instance. Stimulus pushes expected {last, bit} pairs; monitors pop and
// compare whenever O_valid is high.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic       CLK;
    logic       RESET;
    logic [3:0] I;
    logic       I_valid, I_ready, O, O_valid, O_last;
    logic [1:0] I2;
    logic       I_valid2, I_ready2, O2, O_valid2, O_last2;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] q1[$];
    logic [1:0] q2[$];
    int run1 = 0, max_run1 = 0;
    int run2 = 0, max_run2 = 0;

    piso_serializer #(.WIDTH(4)) u_dut (
        .CLK(CLK), .RESET(RESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
        .O(O), .O_valid(O_valid), .O_last(O_last)
    );

    piso_serializer #(.WIDTH(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .I(I2), .I_valid(I_valid2), .I_ready(I_ready2),
        .O(O2), .O_valid(O_valid2), .O_last(O_last2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the WIDTH=4 instance.
    always @(negedge CLK) begin
        logic [1:0] e;
        if (O_valid === 1'b1) begin
            run1++;
            if (run1 > max_run1) max_run1 = run1;
            if (q1.size() == 0) begin
                check("w4_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("w4_O", O, e[0]);
                check("w4_O_last", O_last, e[1]);
            end
        end else begin
            run1 = 0;
            check("w4_idle_O_Olast", {O_last, O}, 2'b00);
        end
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge CLK) begin
        logic [1:0] e;
        if (O_valid2 === 1'b1) begin
            run2++;
            if (run2 > max_run2) max_run2 = run2;
            if (q2.size() == 0) begin
                check("w2_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("w2_O", O2, e[0]);
                check("w2_O_last", O_last2, e[1]);
            end
        end else begin
            run2 = 0;
            check("w2_idle_O_Olast", {O_last2, O2}, 2'b00);
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Expected serial stream: LSB first, then optional even-parity bit.
    task automatic push_exp(input int which, input logic [3:0] w, input int width);
        logic       par;
        logic [1:0] e;
        par = 1'b0;
        for (int k = 0; k < width; k++) begin
            par = par ^ w[k];
            e = {((k == width - 1) && (PE == 0)), w[k]};
            if (which == 2) q2.push_back(e); else q1.push_back(e);
        end
        if (PE == 1) begin
            e = {1'b1, par};
            if (which == 2) q2.push_back(e); else q1.push_back(e);
        end
    endtask

    // Present a word, hold until accepted (bounded), then drop valid.
    task automatic send(input int which, input logic [3:0] w);
        int   n;
        logic rdy;
        if (which == 2) begin I2 = w[1:0]; I_valid2 = 1'b1; end
        else begin I = w; I_valid = 1'b1; end
        n = 0;
        rdy = (which == 2) ? I_ready2 : I_ready;
        while (!rdy && n < 50) begin
            step();
            n++;
            rdy = (which == 2) ? I_ready2 : I_ready;
        end
        check("accept_within_bound", rdy, 1'b1);
        if (rdy) push_exp(which, w, (which == 2) ? 2 : 4);
        step();
        if (which == 2) I_valid2 = 1'b0; else I_valid = 1'b0;
    endtask

    // Wait (bounded) for both scoreboards to empty, then check idle state.
    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
            @(posedge CLK);
            n++;
        end
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q2_empty", q2.size(), 0);
        step();
        check("idle_ready", I_ready, 1'b1);
        check("idle_valid", O_valid, 1'b0);
    endtask

    initial begin
        RESET = 1'b1;
        I = 4'hF; I_valid = 1'b1;       // must be ignored under reset
        I2 = 2'b11; I_valid2 = 1'b1;
        #1;
        check("rst_I_ready", I_ready, 1'b0);
        check("rst_outputs", {O_last, O_valid, O}, 3'b000);
        step(); step();
        check("rst_hold_valid", O_valid, 1'b0);
        check("rst_hold_ready2", I_ready2, 1'b0);
        I_valid = 1'b0; I_valid2 = 1'b0;
        RESET = 1'b0;
        step();
        check("post_rst_ready", I_ready, 1'b1);

        // Single word 4'b1011 -> 1,1,0,1 (then parity 1 when enabled).
        max_run1 = 0;
        send(1, 4'b1011);
        drain();
        check("single_run_len", max_run1, 4 + PE);

        // Back-to-back 4'hA then 4'h5: contiguous stream.
        max_run1 = 0;
        send(1, 4'hA);
        send(1, 4'h5);
        drain();
        check("b2b_run_len", max_run1, 2 * (4 + PE));

        // Stall: 4'h3 held valid while 4'hC shifts; ready only on last bit.
        max_run1 = 0;
        send(1, 4'hC);
        I = 4'h3; I_valid = 1'b1;
        for (int k = 0; k < 4 + PE; k++) begin
            check("stall_ready", I_ready, (k == 4 + PE - 1) ? 1'b1 : 1'b0);
            if (k < 4 + PE - 1) step();
        end
        push_exp(1, 4'h3, 4);
        step();
        I_valid = 1'b0;
        drain();
        check("stall_run_len", max_run1, 2 * (4 + PE));

        // Reset mid-word of 4'hF: outputs drop without a clock edge.
        send(1, 4'hF);
        step();
        #1 RESET = 1'b1;
        #1;
        check("midrst_outputs", {O_last, O_valid, O}, 3'b000);
        check("midrst_ready", I_ready, 1'b0);
        q1.delete();
        step(); step();
        RESET = 1'b0;
        #1;
        check("midrst_release_ready", I_ready, 1'b1);
        send(1, 4'h9);
        drain();

        // Parity-zero word (0011) and WIDTH=2 back-to-back 10 then 01.
        send(1, 4'b0011);
        drain();
        max_run2 = 0;
        send(2, 4'b0010);
        send(2, 4'b0001);
        drain();
        check("w2_b2b_run_len", max_run2, 2 * (2 + PE));
        check("w2_idle_ready", I_ready2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
